// File: rtl/idma_desc64_addr_queue_pkg.sv
// Shared types and defaults for the desc64 descriptor address queue.
package idma_desc64_addr_queue_pkg;

  localparam int unsigned AddrWidthDefault = 64;
  localparam int unsigned AlignLog2Default = 5;

  typedef logic [AddrWidthDefault-1:0] addr_t;

endpackage

// File: rtl/idma_desc64_addr_fifo.sv
// Descriptor address storage: circular buffer with wrap-bit pointers and a flush port.
module idma_desc64_addr_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned IdxW = $clog2(Depth),
  localparam int unsigned PtrW = IdxW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [PtrW-1:0]  usage_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic             do_push, do_pop;

  // Equal index with differing wrap bits means the writer has lapped the reader.
  assign full_o  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                   (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign usage_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[IdxW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) begin
      mem_q[wptr_q[IdxW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/idma_desc64_addr_queue.sv
// Descriptor address queue: alignment filter, FIFO, inflight throttle and sticky error flags.
module idma_desc64_addr_queue
  import idma_desc64_addr_queue_pkg::*;
#(
  parameter int unsigned AddrWidth   = $bits(addr_t),
  parameter int unsigned Depth       = 4,
  parameter int unsigned AlignLog2   = AlignLog2Default,
  parameter int unsigned MaxInflight = 4,
  localparam int unsigned UsageW     = $clog2(Depth + 1),
  localparam int unsigned InflW      = $clog2(MaxInflight + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [AddrWidth-1:0] in_addr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 desc_done_i,
  input  logic                 flush_i,
  input  logic                 err_clear_i,
  output logic [UsageW-1:0]    usage_o,
  output logic [InflW-1:0]     inflight_o,
  output logic                 err_misalign_o,
  output logic                 err_underflow_o
);

  localparam logic [InflW-1:0] MaxInfl = InflW'(MaxInflight);

  logic             fifo_empty, fifo_full;
  logic             push_hs, pop_hs, misaligned, underflow;
  logic [InflW-1:0] inflight_q, inflight_d;
  logic             err_misalign_q, err_misalign_d;
  logic             err_underflow_q, err_underflow_d;

  assign in_ready_o  = rst_ni && !fifo_full && !flush_i;
  assign out_valid_o = rst_ni && !fifo_empty && !flush_i && (inflight_q < MaxInfl);

  assign push_hs    = in_valid_i && in_ready_o;
  assign pop_hs     = out_valid_o && out_ready_i;
  assign misaligned = |in_addr_i[AlignLog2-1:0];
  assign underflow  = desc_done_i && (inflight_q == '0);

  idma_desc64_addr_fifo #(
    .Width (AddrWidth),
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_hs && !misaligned),
    .data_i  (in_addr_i),
    .pop_i   (pop_hs),
    .flush_i (flush_i),
    .data_o  (out_addr_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .usage_o (usage_o)
  );

  always_comb begin
    inflight_d      = inflight_q;
    err_misalign_d  = err_misalign_q;
    err_underflow_d = err_underflow_q;
    if (pop_hs && !desc_done_i) begin
      inflight_d = inflight_q + 1'b1;
    end else if (desc_done_i && !pop_hs && !underflow) begin
      inflight_d = inflight_q - 1'b1;
    end
    // Clear first so a same-cycle set event takes priority.
    if (err_clear_i) begin
      err_misalign_d  = 1'b0;
      err_underflow_d = 1'b0;
    end
    if (push_hs && misaligned) err_misalign_d = 1'b1;
    if (underflow)             err_underflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q      <= '0;
      err_misalign_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      inflight_q      <= inflight_d;
      err_misalign_q  <= err_misalign_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign inflight_o      = inflight_q;
  assign err_misalign_o  = err_misalign_q;
  assign err_underflow_o = err_underflow_q;

endmodule

// File: tb/tb_idma_desc64_addr_queue.sv
// Directed self-checking bench for idma_desc64_addr_queue with default parameters.
module tb_idma_desc64_addr_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_addr;
  logic        in_valid, in_ready;
  logic [63:0] out_addr;
  logic        out_valid, out_ready;
  logic        desc_done, flush, err_clear;
  logic [2:0]  usage, inflight;
  logic        err_misalign, err_underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  idma_desc64_addr_queue dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .in_addr_i       (in_addr),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .out_addr_o      (out_addr),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .desc_done_i     (desc_done),
    .flush_i         (flush),
    .err_clear_i     (err_clear),
    .usage_o         (usage),
    .inflight_o      (inflight),
    .err_misalign_o  (err_misalign),
    .err_underflow_o (err_underflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a);
    in_addr  = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic done();
    desc_done = 1'b1;
    tick();
    desc_done = 1'b0;
  endtask

  logic [63:0] exp_q [4];

  initial begin
    rst_n = 1'b0; in_addr = '0; in_valid = 1'b0; out_ready = 1'b0;
    desc_done = 1'b0; flush = 1'b0; err_clear = 1'b0;
    #2;
    check("rst_in_ready_low", in_ready, 0);
    tick();
    check("rst_usage", usage, 0);
    check("rst_inflight", inflight, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_mis", err_misalign, 0);
    check("rst_err_und", err_underflow, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // 1. Single push visible next cycle.
    push(64'h1000);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_addr", out_addr, 64'h1000);
    check("t1_usage", usage, 1);
    pop();
    check("t1_inflight", inflight, 1);
    check("t1_usage_after_pop", usage, 0);
    done();
    check("t1_inflight_done", inflight, 0);

    // 2. Fill to full, then drain in order.
    exp_q = '{64'h20, 64'h40, 64'h60, 64'h80};
    for (int i = 0; i < 4; i++) push(exp_q[i]);
    check("t2_full_in_ready", in_ready, 0);
    check("t2_usage", usage, 4);
    check("t2_head_stable", out_addr, 64'h20);
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", out_valid, 1);
      check("t2_drain_addr", out_addr, exp_q[i]);
      pop();
    end
    check("t2_empty", usage, 0);
    check("t2_inflight", inflight, 4);
    for (int i = 0; i < 4; i++) done();
    check("t2_inflight_back", inflight, 0);

    // 3. Misaligned address consumed but dropped.
    in_addr = 64'h1004; in_valid = 1'b1;
    #1;
    check("t3_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t3_usage", usage, 0);
    check("t3_err_set", err_misalign, 1);
    tick();
    check("t3_err_sticky", err_misalign, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("t3_err_cleared", err_misalign, 0);

    // 4. Inflight throttle.
    for (int i = 1; i <= 4; i++) push(64'(i) << 8);
    for (int i = 0; i < 4; i++) pop();
    check("t4_inflight_max", inflight, 4);
    push(64'h500);
    check("t4_usage", usage, 1);
    check("t4_throttled", out_valid, 0);
    done();
    check("t4_inflight_3", inflight, 3);
    check("t4_released", out_valid, 1);
    check("t4_fifth_addr", out_addr, 64'h500);
    pop();
    check("t4_inflight_4", inflight, 4);
    for (int i = 0; i < 4; i++) done();
    check("t4_inflight_0", inflight, 0);

    // 5. Push+pop keeps usage; flush beats push.
    push(64'h200); push(64'h220); push(64'h240);
    check("t5_usage3", usage, 3);
    in_addr = 64'h260; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t5_usage_same", usage, 3);
    check("t5_head", out_addr, 64'h220);
    check("t5_inflight", inflight, 1);
    flush = 1'b1; in_addr = 64'h280; in_valid = 1'b1;
    #1;
    check("t5_flush_in_ready", in_ready, 0);
    check("t5_flush_out_valid", out_valid, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flushed_usage", usage, 0);
    check("t5_flushed_valid", out_valid, 0);
    check("t5_flush_inflight", inflight, 1);
    done();
    check("t5_inflight_0", inflight, 0);

    // 6. Underflow, then reset mid-drain.
    done();
    check("t6_underflow", err_underflow, 1);
    check("t6_inflight_0", inflight, 0);
    push(64'h300); push(64'h320); push(64'h301);
    pop();
    check("t6_pre_usage", usage, 1);
    check("t6_pre_inflight", inflight, 1);
    check("t6_pre_mis", err_misalign, 1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_usage", usage, 0);
    check("t6_rst_inflight", inflight, 0);
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_mis", err_misalign, 0);
    check("t6_rst_und", err_underflow, 0);
    rst_n = 1'b1;
    tick();
    check("t6_post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
